mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one downstream channel between two requesters (A, B) by sequencing the select of a 2:1 multiplexer (sel=1 passes A, sel=0 passes B).
- Round-robin arbitration with bounded bursts.
- Valid/ready handshake downstream; per-beat acknowledge to each requester.
- Sits in front of any shared sink (register file write port, display/VGA writer) fed by two producers.

Parameters:
- W, 8, data width of each requester and of the output.
- BURST, 4, maximum accepted beats per grant before forced re-arbitration (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- req_a  in  1  A requests; held high while A has data.
- data_a  in  W  A data; valid when req_a=1.
- req_b  in  1  B requests.
- data_b  in  W  B data.
- out_ready  in  1  sink accepts a beat this cycle.
- out_valid  out  1  beat presented to sink.
- out_data  out  W  muxed data.
- sel  out  1  mux select; 1=A, 0=B.
- ack_a  out  1  A's beat accepted this cycle.
- ack_b  out  1  B's beat accepted this cycle.
- busy  out  1  a grant is held (state not IDLE).

Behaviour:
- Synchronous reset (resetn=0 sampled at a clock edge):
  - state=IDLE, sel=0, burst count=0, last_served=B (A wins the first tie).
  - Outputs during and after reset: out_valid=0, ack_a=0, ack_b=0, busy=0, out_data=data_b (sel=0).
  - Reset mid-burst aborts the grant; no ack is issued in the reset cycle.
- States: IDLE, GNT_A, GNT_B.
- sel is registered from state: 1 in GNT_A, 0 in GNT_B, holds its last value in IDLE.
- Combinational outputs:
  - out_data = sel ? data_a : data_b.
  - out_valid = (GNT_A & req_a) | (GNT_B & req_b).
  - ack_a = GNT_A & req_a & out_ready; ack_b = GNT_B & req_b & out_ready.
  - busy = state != IDLE.
- IDLE transitions:
  - Only req_a -> GNT_A; only req_b -> GNT_B.
  - Both -> grant the requester not equal to last_served.
  - Neither -> stay in IDLE.
  - Latency: request first sampled high in IDLE -> out_valid the next cycle.
- In GNT_x:
  - count increments on each ack_x and is cleared on every grant change or entry from IDLE.
  - Grant ends at the clock edge where either (ack_x and count==BURST-1) or req_x=0.
  - On grant end: last_served=x. Next state is GNT_other if req_other=1; else GNT_x with count=0 if req_x=1 (new burst); else IDLE.
  - A switch between grants takes effect on the next cycle, with no IDLE bubble.
- Backpressure:
  - out_ready=0 holds the grant indefinitely; count is unchanged; data is not acked.
  - The requester must hold data stable until acked.
- Dropped request: if req_x falls while granted, out_valid drops the same cycle, and arbitration proceeds as grant end.
- Simultaneous events:
  - Both requests rising in the same cycle -> tie rule above.
  - A final-beat ack with the other side requesting -> switch.
- BURST=1 degenerates to strict per-beat alternation while both request.
- count width is 4 bits; it never exceeds BURST-1.

Test Plan:
- Reset with resetn=0 for 2 cycles while req_a=req_b=1 -> out_valid=0, ack_a=0, ack_b=0, busy=0, sel=0. After release, GNT_A next cycle: sel=1, out_data=data_a.
- Only A requests, data_a=8'h11..8'h16 (6 beats), out_ready=1, BURST=4 -> 6 consecutive ack_a with no gap. The new burst begins after beat 4 with no IDLE cycle, and B is never granted.
- Both request continuously, out_ready=1, BURST=4 -> ack_a×4, ack_b×4, ack_a×4 repeating, with sel toggling exactly at beat boundaries and no dead cycles.
- In GNT_B after 2 beats, out_ready=0 for 5 cycles while req_a=1 -> sel stays 0, no acks. When ready returns, B completes beats 3 and 4, then switches to A.
- In GNT_A, req_a drops after 1 beat while req_b=1 -> out_valid=0 that cycle, GNT_B next cycle with count=0, and B gets 4 beats.
- Mid-burst reset in GNT_B at count=2 -> IDLE, then last_served=B so a tie grants A.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Purpose:
//   Shares one downstream valid/ready channel between two requesters (A, B)
//   by driving the select of a 2:1 data multiplexer. Grants are handed out
//   round-robin. A grant is held for at most BURST accepted beats, after
//   which the arbiter re-arbitrates. Each requester receives a per-beat
//   acknowledge.
//
// Parameters:
//   W      data width of each requester and of the output
//   BURST  maximum accepted beats per grant (1..15)
//
// Ports:
//   clock      system clock, rising edge
//   resetn     synchronous active-low reset
//   req_a      A requests (held high while A has data)
//   data_a     A data, valid while req_a=1
//   req_b      B requests
//   data_b     B data
//   out_ready  sink accepts a beat this cycle
//   out_valid  beat presented to the sink
//   out_data   muxed data (sel ? data_a : data_b)
//   sel        mux select, 1=A, 0=B
//   ack_a      A's beat accepted this cycle
//   ack_b      B's beat accepted this cycle
//   busy       a grant is held
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
   parameter int W     = 8,
   parameter int BURST = 4
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         req_a,
   input  logic [W-1:0] data_a,
   input  logic         req_b,
   input  logic [W-1:0] data_b,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         sel,
   output logic         ack_a,
   output logic         ack_b,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic [3:0] count_q, count_d;
   // 1 when A was the last requester whose grant ended; reset favours A.
   logic       last_a_q, last_a_d;

   // Outputs depend only on the registered state and the live inputs.
   assign busy      = (state_q != IDLE);
   assign sel       = sel_q;
   assign out_data  = sel_q ? data_a : data_b;
   assign out_valid = ((state_q == GNT_A) && req_a) || ((state_q == GNT_B) && req_b);
   assign ack_a     = (state_q == GNT_A) && req_a && out_ready;
   assign ack_b     = (state_q == GNT_B) && req_b && out_ready;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      last_a_d = last_a_q;

      case (state_q)
         IDLE: begin
            count_d = 4'd0;
            if (req_a && req_b) begin
               state_d = last_a_q ? GNT_B : GNT_A;
            end else if (req_a) begin
               state_d = GNT_A;
            end else if (req_b) begin
               state_d = GNT_B;
            end
         end

         GNT_A: begin
            // Grant ends on the final beat of the burst or when A lets go.
            if ((ack_a && (count_q == LAST_BEAT)) || !req_a) begin
               last_a_d = 1'b1;
               count_d  = 4'd0;
               if (req_b) begin
                  state_d = GNT_B;
               end else if (req_a) begin
                  state_d = GNT_A;
               end else begin
                  state_d = IDLE;
               end
            end else if (ack_a) begin
               count_d = count_q + 4'd1;
            end
         end

         GNT_B: begin
            if ((ack_b && (count_q == LAST_BEAT)) || !req_b) begin
               last_a_d = 1'b0;
               count_d  = 4'd0;
               if (req_a) begin
                  state_d = GNT_A;
               end else if (req_b) begin
                  state_d = GNT_B;
               end else begin
                  state_d = IDLE;
               end
            end else if (ack_b) begin
               count_d = count_q + 4'd1;
            end
         end

         default: begin
            state_d = IDLE;
            count_d = 4'd0;
         end
      endcase

      // sel follows the granted side and keeps its last value in IDLE so the
      // output mux does not glitch between grants.
      case (state_d)
         GNT_A:   sel_d = 1'b1;
         GNT_B:   sel_d = 1'b0;
         default: sel_d = sel_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         count_q  <= 4'd0;
         last_a_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         count_q  <= count_d;
         last_a_q <= last_a_d;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//
// Self-checking bench for mux2_rr_arbiter (W=8, BURST=4). A reference model
// tracks who owns the channel and how many beats it has had; one compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

   localparam int W     = 8;
   localparam int BURST = 4;

   logic         clock;
   logic         resetn;
   logic         req_a;
   logic [W-1:0] data_a;
   logic         req_b;
   logic [W-1:0] data_b;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         sel;
   logic         ack_a;
   logic         ack_b;
   logic         busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   mux2_rr_arbiter #(.W(W), .BURST(BURST)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .req_a     (req_a),
      .data_a    (data_a),
      .req_b     (req_b),
      .data_b    (data_b),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .ack_a     (ack_a),
      .ack_b     (ack_b),
      .busy      (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: 0 nobody, 1 A, 2 B. beats: beats accepted in the current grant.
   int   m_owner = 0;
   int   m_beats = 0;
   int   m_last  = 2;
   logic m_sel   = 1'b0;
   bit   started = 1'b0;

   initial begin
      bit r, ro;
      forever begin
         @(posedge clock);
         if (!resetn) begin
            m_owner = 0;
            m_beats = 0;
            m_last  = 2;
            m_sel   = 1'b0;
            started = 1'b1;
         end else if (started) begin
            if (m_owner == 0) begin
               m_beats = 0;
               if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
               else if (req_a)     m_owner = 1;
               else if (req_b)     m_owner = 2;
            end else begin
               r  = (m_owner == 1) ? req_a : req_b;
               ro = (m_owner == 1) ? req_b : req_a;
               if (r && out_ready) m_beats++;
               if (!r || m_beats == BURST) begin
                  m_last  = m_owner;
                  m_beats = 0;
                  if (ro)      m_owner = 3 - m_owner;
                  else if (!r) m_owner = 0;
               end
            end
            if (m_owner == 1)      m_sel = 1'b1;
            else if (m_owner == 2) m_sel = 1'b0;
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin
      logic         ev, ea, eb, ebusy;
      logic [W-1:0] ed;
      forever begin
         @(negedge clock);
         if (started) begin
            ev    = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
            ea    = (m_owner == 1) && req_a && out_ready;
            eb    = (m_owner == 2) && req_b && out_ready;
            ebusy = (m_owner != 0);
            ed    = m_sel ? data_a : data_b;
            check("model_outputs{valid,ack_a,ack_b,busy,sel,data}",
                  32'({out_valid, ack_a, ack_b, busy, sel, out_data}),
                  32'({ev, ea, eb, ebusy, m_sel, ed}));
         end
      end
   end

   // Waits (bounded) until n acks have been seen on the chosen side.
   task automatic wait_acks(input bit side_b, input int n);
      int seen = 0;
      int k    = 0;
      while (seen < n && k < 50) begin
         @(negedge clock);
         if (side_b ? ack_b : ack_a) seen++;
         k++;
      end
      if (seen < n) check("wait_acks_timeout", 32'(seen), 32'(n));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d", chk_cnt);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] pa, pb, ps;
      logic [5:0]  qa, qb;
      logic [4:0]  ra, rb;
      logic        aa, ab;

      resetn    = 1'b0;
      req_a     = 1'b1;
      req_b     = 1'b1;
      data_a    = 8'hA0;
      data_b    = 8'hB0;
      out_ready = 1'b1;

      // Reset held for two cycles with both requesting.
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_acks", 32'({ack_a, ack_b}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_out_data", 32'(out_data), 32'hB0);
      @(posedge clock);
      #1 resetn = 1'b1;
      @(negedge clock);
      check("idle_before_first_grant", 32'(busy), 32'd0);

      // Both requesting continuously: A x4, B x4, A x4, sel toggling at bursts.
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         pa[11-i] = ack_a;
         pb[11-i] = ack_b;
         ps[11-i] = sel;
         if (i == 0) check("first_grant_data", 32'(out_data), 32'hA0);
      end
      check("both_ack_a_pattern", 32'(pa), 32'b111100001111);
      check("both_ack_b_pattern", 32'(pb), 32'b000011110000);
      check("both_sel_pattern", 32'(ps), 32'b111100001111);

      // Backpressure in GNT_B after two beats, with A still requesting.
      wait_acks(1'b1, 2);
      @(posedge clock);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_sel", 32'(sel), 32'd0);
         check("bp_acks", 32'({ack_a, ack_b}), 32'd0);
      end
      @(posedge clock);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         qa[5-i] = ack_a;
         qb[5-i] = ack_b;
      end
      check("bp_resume_ack_b", 32'(qb), 32'b110000);
      check("bp_resume_ack_a", 32'(qa), 32'b001111);

      // Only A requests, six beats 8'h11..8'h16, burst renewed without a gap.
      @(posedge clock);
      #1 resetn = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h11;
      @(posedge clock);
      #1 resetn = 1'b1; req_a = 1'b1;
      @(posedge clock);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("onlya_ack_a", 32'(ack_a), 32'd1);
         check("onlya_ack_b", 32'(ack_b), 32'd0);
         check("onlya_data", 32'(out_data), 32'(8'h11 + i));
         @(posedge clock);
         #1 data_a = data_a + 8'd1;
         if (i == 5) req_a = 1'b0;
      end

      // A drops after one beat while B requests.
      @(posedge clock);
      #1 resetn = 1'b0; req_a = 1'b0; req_b = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1; req_a = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("drop_first_beat", 32'(ack_a), 32'd1);
      @(posedge clock);
      #1 req_a = 1'b0; req_b = 1'b1;
      @(negedge clock);
      check("drop_out_valid", 32'(out_valid), 32'd0);
      check("drop_busy", 32'(busy), 32'd1);
      @(posedge clock);
      #1 req_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         ra[4-i] = ack_a;
         rb[4-i] = ack_b;
      end
      check("drop_ack_b_pattern", 32'(rb), 32'b11110);
      check("drop_ack_a_pattern", 32'(ra), 32'b00001);

      // Reset in the middle of a B burst; the following tie goes to A.
      @(posedge clock);
      #1 resetn = 1'b0; req_a = 1'b0; req_b = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1; req_b = 1'b1;
      wait_acks(1'b1, 2);
      @(posedge clock);
      #1 resetn = 1'b0; req_a = 1'b1;
      @(posedge clock);
      #1 resetn = 1'b1;
      @(negedge clock);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sel", 32'(sel), 32'd0);
      @(negedge clock);
      check("midrst_tie_sel", 32'(sel), 32'd1);
      check("midrst_tie_ack_a", 32'(ack_a), 32'd1);

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         aa = ack_a;
         ab = ack_b;
         @(posedge clock);
         #1;
         resetn = ($urandom_range(0, 299) != 0);
         if (aa || !req_a) data_a = 8'($urandom);
         if (ab || !req_b) data_b = 8'($urandom);
         if (req_a) req_a = ($urandom_range(0, 9) != 0);
         else       req_a = ($urandom_range(0, 2) == 0);
         if (req_b) req_b = ($urandom_range(0, 9) != 0);
         else       req_b = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clock);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
